// File: rtl/exe_sched_pkg.sv
// Shared types and constants for the round-robin execution-unit scheduler.
package exe_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int NREQ     = 2;
  localparam int STATUS_W = 2;

  function automatic logic [NREQ-1:0] onehot_req(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time
// (the one not named by ptr) is chosen.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       grant,
  output logic       grant_vld
);

  always_comb begin
    grant_vld = |valid;
    if (&valid) begin
      grant = ~ptr;
    end else begin
      grant = valid[1];
    end
  end

endmodule

// File: rtl/exe_unit_rr_sched.sv
// Shares one execution unit between two requesters: latch the winner's operands,
// wait for the unit, capture its result and hand it back to the winner.
module exe_unit_rr_sched
  import exe_sched_pkg::*;
#(
  parameter int m   = 8,
  parameter int n   = 2,
  parameter int LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rsn,
  input  logic [NREQ-1:0]     i_req_valid,
  output logic [NREQ-1:0]     o_req_ready,
  input  logic [n-1:0]        i_oper0,
  input  logic [n-1:0]        i_oper1,
  input  logic [m-1:0]        i_argA0,
  input  logic [m-1:0]        i_argA1,
  input  logic [m-1:0]        i_argB0,
  input  logic [m-1:0]        i_argB1,
  output logic [NREQ-1:0]     o_rsp_valid,
  input  logic [NREQ-1:0]     i_rsp_ready,
  output logic [m-1:0]        o_result,
  output logic [STATUS_W-1:0] o_status,
  output logic [n-1:0]        o_eu_oper,
  output logic [m-1:0]        o_eu_argA,
  output logic [m-1:0]        o_eu_argB,
  input  logic [m-1:0]        i_eu_result,
  input  logic [STATUS_W-1:0] i_eu_status,
  output logic                o_busy
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT);

  sched_state_t     state;
  sched_state_t     state_nxt;
  logic             rr_ptr;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             grant_vld;
  logic             accept;
  logic             capture;
  logic             rsp_done;

  rr_arbiter2 u_arb (
    .valid     (i_req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready is only offered from IDLE, so at most one operation is ever in flight.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    capture     = 1'b0;
    rsp_done    = 1'b0;
    o_req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_vld && !i_rsn) begin
          o_req_ready = onehot_req(grant);
          accept      = 1'b1;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready[owner]) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      rr_ptr      <= 1'b1;
      owner       <= 1'b0;
      cnt         <= '0;
      o_eu_oper   <= '0;
      o_eu_argA   <= '0;
      o_eu_argB   <= '0;
      o_result    <= '0;
      o_status    <= '0;
      o_rsp_valid <= '0;
    end else begin
      if (accept) begin
        o_eu_oper <= grant ? i_oper1 : i_oper0;
        o_eu_argA <= grant ? i_argA1 : i_argA0;
        o_eu_argB <= grant ? i_argB1 : i_argB0;
        owner     <= grant;
        rr_ptr    <= grant;
        cnt       <= CNT_INIT;
      end
      if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      // The response flag is registered so it first appears in the cycle RESP is entered.
      if (capture) begin
        o_result    <= i_eu_result;
        o_status    <= i_eu_status;
        o_rsp_valid <= onehot_req(owner);
      end
      if (rsp_done) begin
        o_rsp_valid <= '0;
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_exe_unit_rr_sched.sv
// Directed bench for exe_unit_rr_sched with a registered model of the execution unit.
module tb_exe_unit_rr_sched;

  logic       clk = 1'b0;
  logic       rsn;
  logic [1:0] reqValid;
  logic [1:0] reqReady;
  logic [1:0] oper0, oper1;
  logic [2:0] argA0, argA1, argB0, argB1;
  logic [1:0] rspValid;
  logic [1:0] rspReady;
  logic [2:0] result;
  logic [1:0] status;
  logic [1:0] euOper;
  logic [2:0] euArgA, euArgB;
  logic [2:0] euResult = '0;
  logic [1:0] euStatus = '0;
  logic       busy;

  int nChecks = 0;
  int nFails  = 0;

  exe_unit_rr_sched #(.m(3), .n(2), .LAT(1)) dut (
    .i_clk       (clk),
    .i_rsn       (rsn),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_oper0     (oper0),
    .i_oper1     (oper1),
    .i_argA0     (argA0),
    .i_argA1     (argA1),
    .i_argB0     (argB0),
    .i_argB1     (argB1),
    .o_rsp_valid (rspValid),
    .i_rsp_ready (rspReady),
    .o_result    (result),
    .o_status    (status),
    .o_eu_oper   (euOper),
    .o_eu_argA   (euArgA),
    .o_eu_argB   (euArgB),
    .i_eu_result (euResult),
    .i_eu_status (euStatus),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // Unit model: 0 AND, 1 OR, 2 SUB, 3 ADD; status = {negative, zero}.
  function automatic logic [2:0] unitResult(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a - b;
      default: return a + b;
    endcase
  endfunction

  always @(posedge clk) begin
    euResult <= unitResult(euOper, euArgA, euArgB);
    euStatus <= {unitResult(euOper, euArgA, euArgB) >= 3'd4, unitResult(euOper, euArgA, euArgB) == 3'd0};
  end

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rspRdy, input logic rst);
    @(negedge clk);
    reqValid = valid;
    rspReady = rspRdy;
    rsn      = rst;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rsn = 1'b1; reqValid = 2'b11; rspReady = 2'b00;
    oper0 = 2'd3; argA0 = 3'b011; argB0 = 3'b001;
    oper1 = 2'd2; argA1 = 3'b001; argB1 = 3'b011;

    // 1: reset with both requesters valid
    applyStimulus(2'b11, 2'b00, 1'b1);
    applyStimulus(2'b11, 2'b00, 1'b1);
    checkOutput("rst_ready",   32'(reqReady), 32'd0);
    checkOutput("rst_rspv",    32'(rspValid), 32'd0);
    checkOutput("rst_busy",    32'(busy),     32'd0);
    checkOutput("rst_euoper",  32'(euOper),   32'd0);
    checkOutput("rst_euargA",  32'(euArgA),   32'd0);
    checkOutput("rst_euargB",  32'(euArgB),   32'd0);
    checkOutput("rst_result",  32'(result),   32'd0);
    checkOutput("rst_status",  32'(status),   32'd0);

    // 2: single request from requester 0, ADD 3+1
    applyStimulus(2'b01, 2'b01, 1'b0);
    checkOutput("t2_ready_T",  32'(reqReady), 32'b01);
    checkOutput("t2_busy_T",   32'(busy),     32'd0);
    applyStimulus(2'b00, 2'b01, 1'b0);
    checkOutput("t2_busy_T1",  32'(busy),     32'd1);
    checkOutput("t2_euoper",   32'(euOper),   32'd3);
    checkOutput("t2_euargA",   32'(euArgA),   32'd3);
    checkOutput("t2_euargB",   32'(euArgB),   32'd1);
    checkOutput("t2_rspv_T1",  32'(rspValid), 32'd0);
    applyStimulus(2'b00, 2'b01, 1'b0);
    checkOutput("t2_busy_T2",  32'(busy),     32'd1);
    checkOutput("t2_rspv_T2",  32'(rspValid), 32'd0);
    applyStimulus(2'b00, 2'b01, 1'b0);
    checkOutput("t2_busy_T3",  32'(busy),     32'd1);
    checkOutput("t2_rspv_T3",  32'(rspValid), 32'b01);
    checkOutput("t2_result",   32'(result),   32'b100);
    checkOutput("t2_status",   32'(status),   32'b10);
    applyStimulus(2'b00, 2'b01, 1'b0);
    checkOutput("t2_busy_T4",  32'(busy),     32'd0);
    checkOutput("t2_rspv_T4",  32'(rspValid), 32'd0);
    checkOutput("t2_result_h", 32'(result),   32'b100);

    // 3: both requesters held valid from reset; expect grants 0,1,0,1 five cycles apart
    oper0 = 2'd0; argA0 = 3'b110; argB0 = 3'b011;
    oper1 = 2'd2; argA1 = 3'b001; argB1 = 3'b011;
    applyStimulus(2'b11, 2'b00, 1'b1);
    checkOutput("t3_rst_ready", 32'(reqReady), 32'd0);
    applyStimulus(2'b11, 2'b00, 1'b0);
    for (int g = 0; g < 4; g++) begin
      if (g != 0) applyStimulus(2'b11, 2'b00, 1'b0);
      checkOutput($sformatf("t3_grant%0d", g), 32'(reqReady), (g % 2) ? 32'b10 : 32'b01);
      applyStimulus(2'b11, 2'b00, 1'b0);
      checkOutput($sformatf("t3_noready1_%0d", g), 32'(reqReady), 32'd0);
      applyStimulus(2'b11, 2'b00, 1'b0);
      checkOutput($sformatf("t3_noready2_%0d", g), 32'(reqReady), 32'd0);
      applyStimulus(2'b11, 2'b00, 1'b0);
      checkOutput($sformatf("t3_rspv%0d", g), 32'(rspValid), (g % 2) ? 32'b10 : 32'b01);
      checkOutput($sformatf("t3_result%0d", g), 32'(result), (g % 2) ? 32'b110 : 32'b010);
      checkOutput($sformatf("t3_status%0d", g), 32'(status), (g % 2) ? 32'b10 : 32'b00);
      checkOutput($sformatf("t3_noready3_%0d", g), 32'(reqReady), 32'd0);
      applyStimulus(2'b11, (g % 2) ? 2'b10 : 2'b01, 1'b0);
      checkOutput($sformatf("t3_rspv_hold%0d", g), 32'(rspValid), (g % 2) ? 32'b10 : 32'b01);
      checkOutput($sformatf("t3_noready4_%0d", g), 32'(reqReady), 32'd0);
    end
    applyStimulus(2'b00, 2'b00, 1'b0);
    checkOutput("t3_end_busy",  32'(busy),     32'd0);
    checkOutput("t3_end_ready", 32'(reqReady), 32'd0);

    // 4: requester 1 OR 4|1, response withheld for three cycles while requester 0 waits
    oper1 = 2'd1; argA1 = 3'b100; argB1 = 3'b001;
    oper0 = 2'd3; argA0 = 3'b001; argB0 = 3'b001;
    applyStimulus(2'b10, 2'b01, 1'b0);
    checkOutput("t4_ready_T",  32'(reqReady), 32'b10);
    applyStimulus(2'b01, 2'b01, 1'b0);
    checkOutput("t4_ready_T1", 32'(reqReady), 32'd0);
    applyStimulus(2'b01, 2'b01, 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2'b01, (c == 3) ? 2'b11 : 2'b01, 1'b0);
      checkOutput($sformatf("t4_rspv%0d", c),   32'(rspValid), 32'b10);
      checkOutput($sformatf("t4_result%0d", c), 32'(result),   32'b101);
      checkOutput($sformatf("t4_status%0d", c), 32'(status),   32'b10);
      checkOutput($sformatf("t4_ready%0d", c),  32'(reqReady), 32'd0);
    end

    // 5: requester 0 granted, then reset while BUSY aborts the operation
    applyStimulus(2'b01, 2'b00, 1'b0);
    checkOutput("t5_grant",    32'(reqReady), 32'b01);
    applyStimulus(2'b00, 2'b00, 1'b1);
    checkOutput("t5_busy_T1",  32'(busy),     32'd1);
    applyStimulus(2'b00, 2'b11, 1'b0);
    checkOutput("t5_idle",     32'(busy),     32'd0);
    checkOutput("t5_rspv0",    32'(rspValid), 32'd0);
    checkOutput("t5_euoper",   32'(euOper),   32'd0);
    checkOutput("t5_result",   32'(result),   32'd0);
    for (int c = 1; c < 3; c++) begin
      applyStimulus(2'b00, 2'b11, 1'b0);
      checkOutput($sformatf("t5_rspv%0d", c), 32'(rspValid), 32'd0);
      checkOutput($sformatf("t5_busy%0d", c), 32'(busy),     32'd0);
    end
    applyStimulus(2'b11, 2'b11, 1'b0);
    checkOutput("t5_ptr_after_rst", 32'(reqReady), 32'b01);

    // 6: requester 0 re-requests while BUSY and withdraws exactly when IDLE returns
    applyStimulus(2'b01, 2'b11, 1'b0);
    checkOutput("t6_ready_T1", 32'(reqReady), 32'd0);
    applyStimulus(2'b01, 2'b11, 1'b0);
    applyStimulus(2'b01, 2'b11, 1'b0);
    checkOutput("t6_rspv",     32'(rspValid), 32'b01);
    checkOutput("t6_result",   32'(result),   32'b010);
    applyStimulus(2'b00, 2'b11, 1'b0);
    checkOutput("t6_nogrant",  32'(reqReady), 32'd0);
    checkOutput("t6_idle",     32'(busy),     32'd0);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(2'b00, 2'b11, 1'b0);
      checkOutput($sformatf("t6_busy%0d", c), 32'(busy),     32'd0);
      checkOutput($sformatf("t6_rspv%0d", c), 32'(rspValid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
